// File: rtl/axis_pkg.sv
// Shared AXI4-Stream definitions: default widths, tuser field offsets and
// the demux FSM state encoding.
package axis_pkg;

    localparam int unsigned AXIS_DATA_WIDTH  = 512;
    localparam int unsigned AXIS_TUSER_WIDTH = 256;

    localparam int unsigned DEST_LSB = 24;
    localparam int unsigned SRC_LSB  = 16;

    typedef enum logic [1:0] {
        IDLE,
        PKT,
        DROP
    } demux_state_t;

endpackage

// File: rtl/axis_fanout_reg.sv
// One-entry hold register that fans a single beat out to several ports,
// tracking per port which targets have not yet taken it.
module axis_fanout_reg #(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned USER_W = 256,
    parameter int unsigned PORTS  = 2
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      load,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [DATA_W/8-1:0]       in_keep,
    input  logic [USER_W-1:0]         in_user,
    input  logic                      in_last,
    input  logic [PORTS-1:0]          in_mask,
    output logic                      in_ready,
    output logic [DATA_W*PORTS-1:0]   m_tdata,
    output logic [DATA_W/8*PORTS-1:0] m_tkeep,
    output logic [USER_W*PORTS-1:0]   m_tuser,
    output logic [PORTS-1:0]          m_tvalid,
    input  logic [PORTS-1:0]          m_tready,
    output logic [PORTS-1:0]          m_tlast
);

    logic                hold_valid;
    logic [PORTS-1:0]    pending;
    logic [DATA_W-1:0]   hold_data;
    logic [DATA_W/8-1:0] hold_keep;
    logic [USER_W-1:0]   hold_user;
    logic                hold_last;
    logic [PORTS-1:0]    still_waiting;

    // Ports that owe a handshake on the current entry but are not ready now.
    assign still_waiting = pending & ~m_tready;
    assign in_ready      = !hold_valid || (still_waiting == '0);

    assign m_tvalid = {PORTS{hold_valid}} & pending;
    assign m_tdata  = {PORTS{hold_data}};
    assign m_tkeep  = {PORTS{hold_keep}};
    assign m_tuser  = {PORTS{hold_user}};
    assign m_tlast  = {PORTS{hold_last}};

    always_ff @(posedge aclk) begin
        if (areset) begin
            hold_valid <= 1'b0;
            pending    <= '0;
            hold_data  <= '0;
            hold_keep  <= '0;
            hold_user  <= '0;
            hold_last  <= 1'b0;
        end else if (load) begin
            hold_valid <= 1'b1;
            pending    <= in_mask;
            hold_data  <= in_data;
            hold_keep  <= in_keep;
            hold_user  <= in_user;
            hold_last  <= in_last;
        end else begin
            pending    <= still_waiting;
            hold_valid <= |still_waiting;
        end
    end

endmodule

// File: rtl/axis_demux.sv
// Packet-granular 1:M AXI4-Stream demultiplexer steered by a multicast mask
// in tuser on each packet's first beat; zero-mask packets are dropped.
module axis_demux
    import axis_pkg::*;
#(
    parameter int unsigned AXIS_DATA_WIDTH  = axis_pkg::AXIS_DATA_WIDTH,
    parameter int unsigned AXIS_TUSER_WIDTH = axis_pkg::AXIS_TUSER_WIDTH,
    parameter int unsigned M_INTF_NUM       = 2,
    parameter int unsigned DEST_LSB         = axis_pkg::DEST_LSB
) (
    input  logic                                  aclk,
    input  logic                                  areset,

    input  logic [AXIS_DATA_WIDTH-1:0]            s_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0]          s_axis_tkeep,
    input  logic [AXIS_TUSER_WIDTH-1:0]           s_axis_tuser,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    input  logic                                  s_axis_tlast,

    output logic [AXIS_DATA_WIDTH*M_INTF_NUM-1:0]   m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8*M_INTF_NUM-1:0] m_axis_tkeep,
    output logic [AXIS_TUSER_WIDTH*M_INTF_NUM-1:0]  m_axis_tuser,
    output logic [M_INTF_NUM-1:0]                   m_axis_tvalid,
    input  logic [M_INTF_NUM-1:0]                   m_axis_tready,
    output logic [M_INTF_NUM-1:0]                   m_axis_tlast,

    output logic [31:0]                           drop_count
);

    demux_state_t          state;
    logic [M_INTF_NUM-1:0] pkt_mask;
    logic [M_INTF_NUM-1:0] first_mask;
    logic [M_INTF_NUM-1:0] load_mask;
    logic                  fan_ready;
    logic                  accept;
    logic                  load;

    assign first_mask    = s_axis_tuser[DEST_LSB +: M_INTF_NUM];
    assign s_axis_tready = !areset && ((state == DROP) || fan_ready);
    assign accept        = s_axis_tvalid && s_axis_tready;

    // Only first beats consult tuser; later beats ride on the latched mask.
    assign load_mask = (state == IDLE) ? first_mask : pkt_mask;
    assign load      = accept && ((state == PKT) ||
                                  (state == IDLE && first_mask != '0));

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            pkt_mask   <= '0;
            drop_count <= '0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (first_mask != '0) begin
                        pkt_mask <= first_mask;
                        state    <= s_axis_tlast ? IDLE : PKT;
                    end else begin
                        if (drop_count != 32'hFFFF_FFFF)
                            drop_count <= drop_count + 32'd1;
                        state <= s_axis_tlast ? IDLE : DROP;
                    end
                end
                PKT, DROP: begin
                    if (s_axis_tlast)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    axis_fanout_reg #(
        .DATA_W (AXIS_DATA_WIDTH),
        .USER_W (AXIS_TUSER_WIDTH),
        .PORTS  (M_INTF_NUM)
    ) u_fanout (
        .aclk     (aclk),
        .areset   (areset),
        .load     (load),
        .in_data  (s_axis_tdata),
        .in_keep  (s_axis_tkeep),
        .in_user  (s_axis_tuser),
        .in_last  (s_axis_tlast),
        .in_mask  (load_mask),
        .in_ready (fan_ready),
        .m_tdata  (m_axis_tdata),
        .m_tkeep  (m_axis_tkeep),
        .m_tuser  (m_axis_tuser),
        .m_tvalid (m_axis_tvalid),
        .m_tready (m_axis_tready),
        .m_tlast  (m_axis_tlast)
    );

endmodule

// File: tb/tb_axis_demux.sv
// Self-checking bench for axis_demux: per-port expected-beat queues built
// from the packet routing rules, compared against the DUT every cycle.
module tb_axis_demux;

    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int UW = 32;
    localparam int M  = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic            clk = 1'b0;
    logic            areset;
    logic [DW-1:0]   s_tdata;
    logic [KW-1:0]   s_tkeep;
    logic [UW-1:0]   s_tuser;
    logic            s_tvalid;
    logic            s_tready;
    logic            s_tlast;
    logic [DW*M-1:0] m_tdata;
    logic [KW*M-1:0] m_tkeep;
    logic [UW*M-1:0] m_tuser;
    logic [M-1:0]    m_tvalid;
    logic [M-1:0]    m_tready = '0;
    logic [M-1:0]    m_tlast;
    logic [31:0]     drop_count;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [M-1:0] rdy_cfg  = 2'b11;
    bit           rand_rdy = 1'b0;

    // Behavioural model state
    beat_t       q0[$];
    beat_t       q1[$];
    bit          in_pkt = 1'b0;
    logic [1:0]  cur_mask = '0;
    int unsigned model_drops = 0;

    logic [DW-1:0] rx0[$];
    logic [DW-1:0] rx1[$];

    axis_demux #(
        .AXIS_DATA_WIDTH  (DW),
        .AXIS_TUSER_WIDTH (UW),
        .M_INTF_NUM       (M),
        .DEST_LSB         (24)
    ) dut (
        .aclk          (clk),
        .areset        (areset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Slave ready from the rules: discarding a packet, or every port still
    // owed a beat is ready to take it now.
    function automatic bit exp_sready();
        bit blocked;
        blocked = (q0.size() != 0 && !m_tready[0]) || (q1.size() != 0 && !m_tready[1]);
        return !areset && ((in_pkt && cur_mask == 2'b00) || !blocked);
    endfunction

    always @(posedge clk) begin
        #2;
        m_tready = rand_rdy ? 2'($urandom) : rdy_cfg;
    end

    // Model update on every clock edge
    always @(posedge clk) begin
        bit    acc;
        beat_t b;
        cyc++;
        if (areset) begin
            q0.delete();
            q1.delete();
            in_pkt      = 1'b0;
            cur_mask    = '0;
            model_drops = 0;
        end else begin
            acc = s_tvalid && exp_sready();
            if (q0.size() != 0 && m_tready[0]) void'(q0.pop_front());
            if (q1.size() != 0 && m_tready[1]) void'(q1.pop_front());
            if (acc) begin
                b = '{d: s_tdata, k: s_tkeep, u: s_tuser, l: s_tlast};
                if (!in_pkt) begin
                    cur_mask = s_tuser[25:24];
                    if (cur_mask == 2'b00) model_drops++;
                end
                if (cur_mask[0]) q0.push_back(b);
                if (cur_mask[1]) q1.push_back(b);
                in_pkt = !s_tlast;
            end
        end
    end

    // Compare process, away from the active edge
    always @(negedge clk) begin
        beat_t e;
        chk("s_tready", 64'(s_tready), 64'(exp_sready()));
        chk("drop_count", 64'(drop_count), 64'(model_drops));
        chk("m_tvalid", 64'(m_tvalid), 64'({q1.size() != 0, q0.size() != 0}));
        for (int i = 0; i < M; i++) begin
            if ((i == 0 && q0.size() != 0) || (i == 1 && q1.size() != 0)) begin
                e = (i == 0) ? q0[0] : q1[0];
                chk($sformatf("tdata[%0d]", i), m_tdata[i*DW +: DW], e.d);
                chk($sformatf("tkeep[%0d]", i), 64'(m_tkeep[i*KW +: KW]), 64'(e.k));
                chk($sformatf("tuser[%0d]", i), 64'(m_tuser[i*UW +: UW]), 64'(e.u));
                chk($sformatf("tlast[%0d]", i), 64'(m_tlast[i]), 64'(e.l));
            end
        end
        if (m_tvalid[0] && m_tready[0]) rx0.push_back(m_tdata[0 +: DW]);
        if (m_tvalid[1] && m_tready[1]) rx1.push_back(m_tdata[DW +: DW]);
    end

    function automatic logic [UW-1:0] mk_user(input logic [1:0] m);
        logic [UW-1:0] u;
        u = $urandom;
        u[25:24] = m;
        return u;
    endfunction

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [UW-1:0] u,
                             input logic l, input bit gap);
        bit acc;
        int n;
        if (gap) begin
            while ($urandom_range(0, 2) == 0) begin
                s_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        s_tdata  = d;
        s_tkeep  = KW'($urandom);
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc) begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 2000) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_timeout: got no handshake expected one within 2000 cycles");
                break;
            end
        end
        s_tvalid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1, t0, t1, len;
        logic [1:0] m;

        areset   = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
        s_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        @(posedge clk);
        #1;
        areset = 1'b0;

        // Unicast 3-beat packet to port 0
        n0 = rx0.size(); n1 = rx1.size();
        send_beat(64'h100, mk_user(2'b01), 1'b0, 1'b0);
        send_beat(64'h101, mk_user(2'b10), 1'b0, 1'b0);
        send_beat(64'h102, mk_user(2'b00), 1'b1, 1'b0);
        idle(4);
        chk("uni_cnt0", 64'(rx0.size() - n0), 64'd3);
        chk("uni_cnt1", 64'(rx1.size() - n1), 64'd0);
        chk("uni_first", rx0[n0], 64'h100);
        chk("uni_last", rx0[n0+2], 64'h102);

        // Multicast with port 1 stalled
        rdy_cfg = 2'b01;
        fork
            begin
                send_beat(64'h200, mk_user(2'b11), 1'b0, 1'b0);
                send_beat(64'h201, mk_user(2'b01), 1'b1, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                rdy_cfg = 2'b11;
            end
        join
        idle(4);
        chk("mc_p0_b0", rx0[rx0.size()-2], 64'h200);
        chk("mc_p0_b1", rx0[rx0.size()-1], 64'h201);
        chk("mc_p1_b0", rx1[rx1.size()-2], 64'h200);
        chk("mc_p1_b1", rx1[rx1.size()-1], 64'h201);

        // Zero-mask packet dropped, then single beat to port 1
        n0 = rx0.size(); n1 = rx1.size();
        send_beat(64'h2F0, mk_user(2'b00), 1'b0, 1'b0);
        for (int b = 1; b < 5; b++)
            send_beat(64'h2F0 + 64'(b), mk_user(2'($urandom)), b == 4, 1'b0);
        send_beat(64'h300, mk_user(2'b10), 1'b1, 1'b0);
        idle(4);
        chk("drop_count_1", 64'(drop_count), 64'd1);
        chk("drop_model_1", 64'(model_drops), 64'd1);
        chk("drop_p0_none", 64'(rx0.size() - n0), 64'd0);
        chk("drop_p1_beat", rx1[rx1.size()-1], 64'h300);

        // Mask latched from first beat only
        n0 = rx0.size(); n1 = rx1.size();
        send_beat(64'h400, mk_user(2'b01), 1'b0, 1'b0);
        send_beat(64'h401, mk_user(2'b10), 1'b1, 1'b0);
        idle(4);
        chk("latch_cnt0", 64'(rx0.size() - n0), 64'd2);
        chk("latch_cnt1", 64'(rx1.size() - n1), 64'd0);
        chk("latch_last", rx0[rx0.size()-1], 64'h401);

        // Back-to-back single-beat packets, no bubbles
        n0 = rx0.size(); n1 = rx1.size();
        t0 = cyc;
        for (int k = 0; k < 10; k++)
            send_beat(64'h500 + 64'(k), mk_user((k % 2 == 0) ? 2'b01 : 2'b10), 1'b1, 1'b0);
        t1 = cyc;
        idle(4);
        chk("b2b_cycles", 64'(t1 - t0), 64'd10);
        chk("b2b_cnt0", 64'(rx0.size() - n0), 64'd5);
        chk("b2b_cnt1", 64'(rx1.size() - n1), 64'd5);

        // Randomized traffic and backpressure
        rand_rdy = 1'b1;
        for (int p = 0; p < 200; p++) begin
            len = $urandom_range(1, 4);
            m   = 2'($urandom);
            for (int b = 0; b < len; b++)
                send_beat({16'(p), 8'(b), 40'($urandom)},
                          (b == 0) ? mk_user(m) : UW'($urandom), b == len - 1, 1'b1);
        end
        rand_rdy = 1'b0;
        rdy_cfg  = 2'b11;
        idle(6);

        // Reset in the middle of a 4-beat packet
        send_beat(64'h600, mk_user(2'b11), 1'b0, 1'b0);
        send_beat(64'h601, mk_user(2'b00), 1'b0, 1'b0);
        s_tdata  = 64'h602;
        s_tuser  = mk_user(2'b11);
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        areset   = 1'b1;
        @(posedge clk);
        #1;
        areset   = 1'b0;
        s_tvalid = 1'b0;
        @(negedge clk);
        chk("rstmid_tvalid", 64'(m_tvalid), 64'd0);
        chk("rstmid_drops", 64'(drop_count), 64'd0);
        @(posedge clk);
        #1;
        n0 = rx0.size(); n1 = rx1.size();
        send_beat(64'h700, mk_user(2'b10), 1'b1, 1'b0);
        idle(4);
        chk("rstmid_p1_cnt", 64'(rx1.size() - n1), 64'd1);
        chk("rstmid_p1_beat", rx1[rx1.size()-1], 64'h700);
        chk("rstmid_p0_cnt", 64'(rx0.size() - n0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
